// File: rtl/snake_head_mover.sv
// Snake head mover: takes one-hot direction requests, blocks 180-degree reversals,
// moves the head one cell every TICK_DIV clocks and stops in CRASH at a wall.
module snake_head_mover #(
  parameter int GRID_W   = 16,
  parameter int GRID_H   = 16,
  parameter int X_W      = 4,
  parameter int Y_W      = 4,
  parameter int TICK_DIV = 4,
  parameter int CNT_W    = 8,
  parameter int START_X  = 8,
  parameter int START_Y  = 8
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           start,
  input  logic           dir_valid,
  input  logic           dir_up,
  input  logic           dir_down,
  input  logic           dir_left,
  input  logic           dir_right,
  output logic [X_W-1:0] head_x,
  output logic [Y_W-1:0] head_y,
  output logic [1:0]     cur_dir,
  output logic           moving,
  output logic           step,
  output logic           crash,
  output logic [1:0]     state_dbg
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    CRASH = 2'd2
  } state_t;

  state_t           state, state_nxt;
  logic [1:0]       pend_dir;
  logic [CNT_W-1:0] tick_cnt;

  logic       tick, hit_wall, dir_ok, accept, restart;
  logic [2:0] hot_cnt;
  logic [1:0] dir_code, ref_dir;

  assign state_dbg = state;

  // dir_valid is a strobe with no back-pressure: a request is taken in the cycle
  // it is presented or lost; there is no ready and nothing is buffered.
  always_comb begin
    hot_cnt  = 3'(dir_up) + 3'(dir_down) + 3'(dir_left) + 3'(dir_right);
    dir_ok   = dir_valid && (hot_cnt == 3'd1);
    dir_code = dir_right ? 2'b00 :
               dir_left  ? 2'b01 :
               dir_up    ? 2'b10 : 2'b11;
    tick     = (state == RUN) && (tick_cnt == CNT_W'(TICK_DIV - 1));
    // On the step cycle the direction being committed is the one to not reverse.
    ref_dir  = tick ? pend_dir : cur_dir;
    accept   = dir_ok && (dir_code != {ref_dir[1], ~ref_dir[0]});
    restart  = start && (state != RUN);
    hit_wall = 1'b0;
    case (pend_dir)
      2'b00:   hit_wall = (head_x == X_W'(GRID_W - 1));
      2'b01:   hit_wall = (head_x == '0);
      2'b10:   hit_wall = (head_y == '0);
      default: hit_wall = (head_y == Y_W'(GRID_H - 1));
    endcase
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = RUN;
      RUN:     if (tick && hit_wall) state_nxt = CRASH;
      CRASH:   if (start) state_nxt = RUN;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_nxt;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      head_x   <= X_W'(START_X);
      head_y   <= Y_W'(START_Y);
      cur_dir  <= 2'b00;
      pend_dir <= 2'b00;
      tick_cnt <= '0;
      step     <= 1'b0;
      moving   <= 1'b0;
      crash    <= 1'b0;
    end else begin
      step   <= 1'b0;
      moving <= (state_nxt == RUN);
      crash  <= (state_nxt == CRASH);
      if (restart) begin
        head_x   <= X_W'(START_X);
        head_y   <= Y_W'(START_Y);
        cur_dir  <= 2'b00;
        pend_dir <= 2'b00;
        tick_cnt <= '0;
      end else begin
        if (accept) pend_dir <= dir_code;
        if (state == RUN) begin
          if (tick) begin
            tick_cnt <= '0;
            cur_dir  <= pend_dir;
            if (!hit_wall) begin
              step <= 1'b1;
              case (pend_dir)
                2'b00:   head_x <= head_x + 1'b1;
                2'b01:   head_x <= head_x - 1'b1;
                2'b10:   head_y <= head_y - 1'b1;
                default: head_y <= head_y + 1'b1;
              endcase
            end
          end else begin
            tick_cnt <= tick_cnt + 1'b1;
          end
        end
      end
    end
  end

endmodule
